vmicro16_timern_apb: RTL and testbench

VMICRO16_TIMERN_APB -- requirements
Module: vmicro16_timern_apb

---
 rtl/vmicro16_timern_pkg.sv | 23 ++
 rtl/vmicro16_timern_chan.sv | 70 +++++++
 rtl/vmicro16_timern_apb.sv | 127 ++++++++++++
 tb/tb_vmicro16_timern_apb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vmicro16_timern_pkg.sv
// Shared definitions for the vmicro16 multi-channel APB timer: register map and CTRL bit layout.
package vmicro16_timern_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_BITS     = 3;

    localparam int PRESCALE_BITS = 8;

    // Channel-select width, never narrower than one bit.
    function automatic int ch_bits(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/vmicro16_timern_chan.sv
// One timer channel: down-counter with reload, sticky W1C status and a one-cycle interrupt pulse.
module vmicro16_timern_chan
    import vmicro16_timern_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TIMER_WIDTH = 16,
    parameter int CH_INDEX    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   wr_ctrl,
    input  logic                   wr_load,
    input  logic                   wr_status,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [CTRL_BITS-1:0]   ctrl,
    output logic [TIMER_WIDTH-1:0] load,
    output logic [TIMER_WIDTH-1:0] count,
    output logic                   status,
    output logic                   irq,
    output logic [DATA_WIDTH-1:0]  irq_data
);

    localparam int LOW_BITS = DATA_WIDTH - 4;

    logic                  expire;
    logic [DATA_WIDTH-1:0] payload;
    logic                  unused_wdata;

    assign expire       = ctrl[CTRL_EN] & tick & (count == '0);
    assign payload      = {4'(CH_INDEX), LOW_BITS'(load)};
    assign unused_wdata = &{1'b0, wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            load     <= '0;
            count    <= '0;
            status   <= 1'b0;
            irq      <= 1'b0;
            irq_data <= '0;
        end else begin
            irq <= expire & ctrl[CTRL_IRQ_EN];
            if (expire & ctrl[CTRL_IRQ_EN])
                irq_data <= payload;

            if (wr_ctrl)
                ctrl <= wdata[CTRL_BITS-1:0];
            else if (expire & ~ctrl[CTRL_PERIODIC])
                ctrl[CTRL_EN] <= 1'b0;

            // A LOAD write overrides both the decrement and an expiry reload.
            if (wr_load) begin
                load  <= wdata[TIMER_WIDTH-1:0];
                count <= wdata[TIMER_WIDTH-1:0];
            end else if (ctrl[CTRL_EN] & tick) begin
                if (count != '0)
                    count <= count - TIMER_WIDTH'(1);
                else if (ctrl[CTRL_PERIODIC])
                    count <= load;
            end

            if (expire)
                status <= 1'b1;
            else if (wr_status & wdata[0])
                status <= 1'b0;
        end
    end

endmodule

// File: rtl/vmicro16_timern_apb.sv
// APB slave with CHANNELS independent down-counting timers and per-channel interrupt payloads.
// Optional shared prescaler register enabled by defining VMICRO16_TIMERN_PRESCALE_EN.
module vmicro16_timern_apb
    import vmicro16_timern_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CHANNELS    = 4,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BUS_WIDTH-1:0]           S_PADDR,
    input  logic                           S_PWRITE,
    input  logic                           S_PSELx,
    input  logic                           S_PENABLE,
    input  logic [DATA_WIDTH-1:0]          S_PWDATA,
    output logic [DATA_WIDTH-1:0]          S_PRDATA,
    output logic                           S_PREADY,
    output logic [CHANNELS-1:0]            ints,
    output logic [CHANNELS*DATA_WIDTH-1:0] ints_data
);

    localparam int CH_BITS = ch_bits(CHANNELS);
    localparam int SLOTS   = 2 ** CH_BITS;

    logic             access;
    logic             wr;
    reg_e             reg_sel;
    logic [CH_BITS:0] ch_idx;
    logic [CH_BITS-1:0] ch_sel;
    logic             ch_valid;
    logic             prescale_sel;
    logic             tick;
    logic             unused_addr;

    logic [CTRL_BITS-1:0]   ctrl_q   [SLOTS];
    logic [TIMER_WIDTH-1:0] load_q   [SLOTS];
    logic [TIMER_WIDTH-1:0] count_q  [SLOTS];
    logic                   status_q [SLOTS];

    // Zero-wait-state APB: ready whenever PSEL and PENABLE are both high.
    assign access   = S_PSELx & S_PENABLE;
    assign S_PREADY = access;
    assign wr       = access & S_PWRITE;

    // One extra channel bit so the slot just past the last channel is addressable.
    assign reg_sel      = reg_e'(S_PADDR[1:0]);
    assign ch_idx       = S_PADDR[CH_BITS+2:2];
    assign ch_sel       = ch_idx[CH_BITS-1:0];
    assign ch_valid     = ch_idx < (CH_BITS+1)'(CHANNELS);
    assign prescale_sel = (ch_idx == (CH_BITS+1)'(CHANNELS)) && (reg_sel == REG_CTRL);
    assign unused_addr  = &{1'b0, S_PADDR[BUS_WIDTH-1:CH_BITS+3]};

    for (genvar ch = 0; ch < SLOTS; ch++) begin : g_chan
        if (ch < CHANNELS) begin : g_live
            logic sel;
            assign sel = wr & ch_valid & (ch_sel == CH_BITS'(ch));

            vmicro16_timern_chan #(
                .DATA_WIDTH (DATA_WIDTH),
                .TIMER_WIDTH(TIMER_WIDTH),
                .CH_INDEX   (ch)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .tick     (tick),
                .wr_ctrl  (sel && (reg_sel == REG_CTRL)),
                .wr_load  (sel && (reg_sel == REG_LOAD)),
                .wr_status(sel && (reg_sel == REG_STATUS)),
                .wdata    (S_PWDATA),
                .ctrl     (ctrl_q[ch]),
                .load     (load_q[ch]),
                .count    (count_q[ch]),
                .status   (status_q[ch]),
                .irq      (ints[ch]),
                .irq_data (ints_data[ch*DATA_WIDTH +: DATA_WIDTH])
            );
        end else begin : g_none
            assign ctrl_q[ch]   = '0;
            assign load_q[ch]   = '0;
            assign count_q[ch]  = '0;
            assign status_q[ch] = 1'b0;
        end
    end

`ifdef VMICRO16_TIMERN_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] prescale_q;
    logic [PRESCALE_BITS-1:0] pre_cnt_q;

    assign tick = (pre_cnt_q == prescale_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else if (wr & prescale_sel) begin
            prescale_q <= S_PWDATA[PRESCALE_BITS-1:0];
            pre_cnt_q  <= '0;
        end else begin
            pre_cnt_q <= tick ? '0 : pre_cnt_q + PRESCALE_BITS'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        S_PRDATA = '0;
        if (access) begin
            if (ch_valid) begin
                case (reg_sel)
                    REG_CTRL:   S_PRDATA = DATA_WIDTH'(ctrl_q[ch_sel]);
                    REG_LOAD:   S_PRDATA = DATA_WIDTH'(load_q[ch_sel]);
                    REG_COUNT:  S_PRDATA = DATA_WIDTH'(count_q[ch_sel]);
                    REG_STATUS: S_PRDATA = DATA_WIDTH'(status_q[ch_sel]);
                endcase
            end
`ifdef VMICRO16_TIMERN_PRESCALE_EN
            else if (prescale_sel) begin
                S_PRDATA = DATA_WIDTH'(prescale_q);
            end
`endif
        end
    end

endmodule

// File: tb/tb_vmicro16_timern_apb.sv
// Directed self-checking bench for vmicro16_timern_apb in its default build (no prescaler).
module tb_vmicro16_timern_apb;
    import vmicro16_timern_pkg::*;

    localparam int BW = 32;
    localparam int DW = 32;
    localparam int CH = 4;
    localparam int TW = 16;

    logic              clk;
    logic              reset;
    logic [BW-1:0]     paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic [CH-1:0]     ints;
    logic [CH*DW-1:0]  ints_data;

    vmicro16_timern_apb #(
        .BUS_WIDTH  (BW),
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .TIMER_WIDTH(TW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .S_PADDR  (paddr),
        .S_PWRITE (pwrite),
        .S_PSELx  (psel),
        .S_PENABLE(penable),
        .S_PWDATA (pwdata),
        .S_PRDATA (prdata),
        .S_PREADY (pready),
        .ints     (ints),
        .ints_data(ints_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] a(input int ch, input int r);
        return 32'(ch * 4 + r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
    endtask

    // Setup on one edge, access on the next; the write commits on the third edge.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        data = prdata;
        check("pready_access", {31'b0, pready}, 32'd1);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic observe(input int ch, input int n, output logic [31:0] pat);
        pat = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            pat[k] = ints[ch];
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] rd;
        check({tag, "_ints"}, {28'b0, ints}, 32'd0);
        check({tag, "_ints_data_or"}, {31'b0, |ints_data}, 32'd0);
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(a(c, r), rd);
                check($sformatf("%s_c%0d_r%0d", tag, c, r), rd, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] pat;

        vecs[0]  = '{1'b1, a(3, 1), 32'hABCD1234, 32'h0,    "w_load3"};
        vecs[1]  = '{1'b0, a(3, 1), 32'h0,        32'h1234, "load_trunc"};
        vecs[2]  = '{1'b0, a(3, 2), 32'h0,        32'h1234, "count_follows_load"};
        vecs[3]  = '{1'b1, a(3, 0), 32'hFFFFFFF6, 32'h0,    "w_ctrl3"};
        vecs[4]  = '{1'b0, a(3, 0), 32'h0,        32'h6,    "ctrl_mask"};
        vecs[5]  = '{1'b0, a(3, 3), 32'h0,        32'h0,    "status_idle"};
        vecs[6]  = '{1'b1, a(2, 1), 32'h55,       32'h0,    "w_load2"};
        vecs[7]  = '{1'b0, a(2, 1), 32'h0,        32'h55,   "load_ch2"};
        vecs[8]  = '{1'b0, a(3, 1), 32'h0,        32'h1234, "load_ch3_isolated"};
        vecs[9]  = '{1'b1, a(4, 0), 32'hFF,       32'h0,    "w_prescale"};
        vecs[10] = '{1'b0, a(4, 0), 32'h0,        32'h0,    "prescale_absent"};
        vecs[11] = '{1'b0, a(4, 1), 32'h0,        32'h0,    "ch_oob_read"};
        vecs[12] = '{1'b1, a(4, 1), 32'hFFFF,     32'h0,    "w_oob_load"};
        vecs[13] = '{1'b0, a(0, 1), 32'h0,        32'h0,    "oob_no_alias_load"};
        vecs[14] = '{1'b0, a(0, 0), 32'h0,        32'h0,    "oob_no_alias_ctrl"};

        bus_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("idle_pready", {31'b0, pready}, 32'd0);
        check("idle_prdata", prdata, 32'd0);
        check_all_zero("reset");

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                apb_read(vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end

        // Setup phase alone must not drive read data or ready.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a(3, 1);
        #1;
        check("setup_prdata", prdata, 32'd0);
        check("setup_pready", {31'b0, pready}, 32'd0);
        @(posedge clk); #1;
        bus_idle();

        // Periodic LOAD=3 with IRQ: pulse every 4 cycles.
        apb_write(a(0, 1), 32'd3);
        apb_write(a(0, 0), 32'h7);
        observe(0, 16, pat);
        check("periodic_ch0_pattern", pat, 32'h8888);
        check("periodic_ch0_data", ints_data[0 +: DW], 32'h00000003);
        apb_read(a(0, 3), rd);
        check("periodic_ch0_status", rd, 32'd1);
        apb_write(a(0, 0), 32'h0);
        apb_write(a(0, 3), 32'h1);
        apb_read(a(0, 3), rd);
        check("status_w1c", rd, 32'd0);

        // One-shot LOAD=2: single pulse 3 cycles after enable, EN self-clears.
        apb_write(a(1, 1), 32'd2);
        apb_write(a(1, 0), 32'h5);
        observe(1, 10, pat);
        check("oneshot_ch1_pattern", pat, 32'h4);
        check("oneshot_ch1_data", ints_data[DW +: DW], 32'h10000002);
        apb_read(a(1, 0), rd);
        check("oneshot_ch1_ctrl", rd, 32'h4);
        apb_read(a(1, 2), rd);
        check("oneshot_ch1_count", rd, 32'd0);

        // LOAD=0 periodic: expiry every tick; W1C cannot beat a simultaneous expiry.
        apb_write(a(2, 1), 32'd0);
        apb_write(a(2, 0), 32'h7);
        observe(2, 8, pat);
        check("load0_ch2_pattern", pat, 32'hFF);
        apb_write(a(2, 3), 32'h1);
        apb_read(a(2, 3), rd);
        check("w1c_vs_expiry", rd, 32'd1);

        // LOAD write on an expiry edge: COUNT takes the written value, irq still fires.
        apb_write(a(2, 1), 32'd9);
        check("load_vs_expiry_irq", {31'b0, ints[2]}, 32'd1);
        apb_read(a(2, 2), rd);
        check("load_vs_expiry_count", rd, 32'd7);
        check("load_vs_expiry_data", ints_data[2*DW +: DW], 32'h20000000);
        apb_write(a(2, 0), 32'h0);

        // Re-enabling resumes from the current COUNT rather than reloading.
        apb_write(a(3, 1), 32'd10);
        apb_write(a(3, 0), 32'h1);
        apb_write(a(3, 0), 32'h0);
        apb_read(a(3, 2), rd);
        check("pause_count", rd, 32'd7);
        apb_write(a(3, 0), 32'h1);
        apb_read(a(3, 2), rd);
        check("resume_count", rd, 32'd5);
        apb_write(a(3, 0), 32'h0);

        // No prescaler: LOAD=1 periodic expires every 2 cycles.
        apb_write(a(1, 1), 32'd1);
        apb_write(a(1, 0), 32'h7);
        observe(1, 8, pat);
        check("noprescale_ch1_pattern", pat, 32'hAA);
        apb_write(a(1, 0), 32'h0);

        // Reset mid-count with a write in its access phase.
        apb_write(a(0, 1), 32'd8);
        apb_write(a(0, 0), 32'h1);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a(0, 1); pwdata = 32'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        reset   = 1'b1;
        #1;
        check("reset_access_pready", {31'b0, pready}, 32'd1);
        check("reset_access_prdata", prdata, 32'd8);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_idle();
        check_all_zero("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
